// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780 read engine (RW=1), reassembles one byte per request.
// Define LCD_BUSY_POLL_EN to repeat status reads while BF=1, up to MAX_POLLS.
module lcd_reader #(
  parameter int T_SETUP   = 2,
  parameter int T_EH      = 12,
  parameter int T_HOLD    = 2,
  parameter int T_GAP     = 50,
  parameter int MAX_POLLS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       timeout,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [3:0] lcd_d,
  output logic       drv_en
);

  localparam int MAX_A   = (T_SETUP > T_EH) ? T_SETUP : T_EH;
  localparam int MAX_B   = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > MAX_POLLS) ? MAX_C : MAX_POLLS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, SETUP_H, EH_H, HOLD_H, GAP, SETUP_L, EH_L, HOLD_L, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_rw_q, lcd_rw_d;
  logic          drv_en_q, drv_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last;

`ifdef LCD_BUSY_POLL_EN
  logic [CW-1:0] poll_q, poll_d;
  logic          repoll_q, repoll_d;
  logic          timeout_q, timeout_d;
`endif

  // Each timed state starts at its parameter minus one and exits on zero.
  function automatic logic [CW-1:0] load_for(input state_t s);
    case (s)
      SETUP_H, SETUP_L: return CW'(T_SETUP - 1);
      EH_H, EH_L:       return CW'(T_EH - 1);
      HOLD_H, HOLD_L:   return CW'(T_HOLD - 1);
      GAP:              return CW'(T_GAP - 1);
      default:          return '0;
    endcase
  endfunction

  assign last = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    lcd_rs_d = lcd_rs_q;
`ifdef LCD_BUSY_POLL_EN
    poll_d    = poll_q;
    repoll_d  = repoll_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP_H;
          lcd_rs_d = rs_sel;
`ifdef LCD_BUSY_POLL_EN
          poll_d   = '0;
          repoll_d = 1'b0;
`endif
        end
      end
      SETUP_H: if (last) state_d = EH_H;
      EH_H: begin
        if (last) begin
          state_d      = HOLD_H;
          rdata_d[7:4] = lcd_d;
        end
      end
      HOLD_H: if (last) state_d = GAP;
      GAP: begin
        if (last) begin
`ifdef LCD_BUSY_POLL_EN
          state_d  = repoll_q ? SETUP_H : SETUP_L;
          repoll_d = 1'b0;
`else
          state_d  = SETUP_L;
`endif
        end
      end
      SETUP_L: if (last) state_d = EH_L;
      EH_L: begin
        if (last) begin
          state_d      = HOLD_L;
          rdata_d[3:0] = lcd_d;
        end
      end
      HOLD_L: begin
        if (last) begin
`ifdef LCD_BUSY_POLL_EN
          // poll_q counts reads finished before the one ending now
          if (!lcd_rs_q && rdata_q[7] && (poll_q < CW'(MAX_POLLS - 1))) begin
            state_d  = GAP;
            repoll_d = 1'b1;
            poll_d   = poll_q + 1'b1;
          end else begin
            state_d   = DONE;
            timeout_d = !lcd_rs_q && rdata_q[7];
          end
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = load_for(state_d);
    else if (!last)         cnt_d = cnt_q - 1'b1;

    // Outputs are registered images of the next state.
    lcd_e_d  = (state_d == EH_H) || (state_d == EH_L);
    lcd_rw_d = (state_d != IDLE) && (state_d != DONE);
    drv_en_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= 8'h00;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_rw_q <= 1'b0;
      drv_en_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q    <= '0;
      repoll_q  <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_rw_q <= lcd_rw_d;
      drv_en_q <= drv_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LCD_BUSY_POLL_EN
      poll_q    <= poll_d;
      repoll_q  <= repoll_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign lcd_e  = lcd_e_q;
  assign lcd_rs = lcd_rs_q;
  assign lcd_rw = lcd_rw_q;
  assign drv_en = drv_en_q;
`ifdef LCD_BUSY_POLL_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: table of single reads, back-to-back, abort, optional busy polling.
module tb_lcd_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rs_sel;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       timeout;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_d;
  logic       drv_en;

  lcd_reader dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rs_sel (rs_sel),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .timeout(timeout),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_d  (lcd_d),
    .drv_en (drv_en)
  );

  always #10 clk = ~clk;

  // LCD model: high nibble on the first E pulse, low nibble on the second;
  // each completed read moves to the next byte of model_bytes (last one sticks).
  logic [7:0] model_bytes [0:7];
  int         last_idx;
  int         rd_idx;
  logic       nib_phase;
  logic       e_q;
  logic [7:0] cur_byte;

  always @(posedge clk) begin
    if (!rst_n || (start && !busy)) begin
      rd_idx    <= 0;
      nib_phase <= 1'b0;
    end else if (e_q && !lcd_e) begin
      nib_phase <= ~nib_phase;
      if (nib_phase) rd_idx <= rd_idx + 1;
    end
    e_q <= lcd_e;
  end

  always_comb begin
    cur_byte = model_bytes[(rd_idx > last_idx) ? last_idx : rd_idx];
    lcd_d    = 4'h0;
    if (lcd_e) lcd_d = nib_phase ? cur_byte[3:0] : cur_byte[7:4];
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic       to;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [5];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One request from IDLE; samples every cycle until one past the expected done.
  task automatic do_read(input logic rs, input logic [7:0] exp_rd, input logic exp_to,
                         input int exp_lat, input int exp_reads);
    int done_at = 0, done_cnt = 0, rw_cnt = 0;
    int rs_bad = 0, drv_bad = 0, busy_bad = 0;
    int pulses = 0, hi_run = 0, low_run = 0;
    int min_w = 9999, max_w = 0, min_g = 9999, max_g = 0;
    logic e_prev = 1'b0;
    exp_t e;
    @(negedge clk);
    rs_sel = rs;
    start  = 1'b1;
    for (int n = 1; n <= exp_lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        sb_q.push_back('{rdata: exp_rd, to: exp_to});
      end
      if (n == 40) rs_sel = ~rs;
      if (lcd_rw) rw_cnt++;
      if (n <= exp_lat && lcd_rs !== rs) rs_bad++;
      if (drv_en !== (n > exp_lat)) drv_bad++;
      if (busy !== (n <= exp_lat)) busy_bad++;
      if (lcd_e) begin
        if (!e_prev) begin
          if (pulses > 0) begin
            if (low_run < min_g) min_g = low_run;
            if (low_run > max_g) max_g = low_run;
          end
          hi_run = 1;
        end else hi_run++;
      end else begin
        if (e_prev) begin
          pulses++;
          if (hi_run < min_w) min_w = hi_run;
          if (hi_run > max_w) max_w = hi_run;
          low_run = 1;
        end else low_run++;
      end
      e_prev = lcd_e;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rdata", {24'h0, rdata}, {24'h0, e.rdata});
          chk("timeout", {31'h0, timeout}, {31'h0, e.to});
        end else chk("spurious_done", {31'h0, done}, 32'h0);
      end
    end
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_at, exp_lat);
    chk("rw_high_cycles", rw_cnt, exp_lat - 1);
    chk("rs_stable", rs_bad, 0);
    chk("drv_en_window", drv_bad, 0);
    chk("busy_window", busy_bad, 0);
    chk("e_pulse_count", pulses, 2 * exp_reads);
    chk("e_width_min", min_w, 12);
    chk("e_width_max", max_w, 12);
    chk("e_gap_min", min_g, 54);
    chk("e_gap_max", max_g, 54);
    chk("reads_done", rd_idx, exp_reads);
    sb_q.delete();
  endtask

  initial begin
    int dcnt;
    int done_w[$];
    exp_t e;

    rst_n = 1'b0;
    start = 1'b0;
    rs_sel = 1'b0;
    last_idx = 0;
    for (int i = 0; i < 8; i++) model_bytes[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_lcd_e", {31'h0, lcd_e}, 32'h0);
    chk("rst_lcd_rw", {31'h0, lcd_rw}, 32'h0);
    chk("rst_lcd_rs", {31'h0, lcd_rs}, 32'h0);
    chk("rst_drv_en", {31'h0, drv_en}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);
    rst_n = 1'b1;

    vecs[0] = '{rs: 1'b0, b: 8'h47, exp: 8'h47};
    vecs[1] = '{rs: 1'b1, b: 8'h41, exp: 8'h41};
    vecs[2] = '{rs: 1'b1, b: 8'hA5, exp: 8'hA5};
    vecs[3] = '{rs: 1'b0, b: 8'h3C, exp: 8'h3C};
    vecs[4] = '{rs: 1'b1, b: 8'hFF, exp: 8'hFF};
    for (int v = 0; v < 5; v++) begin
      model_bytes[0] = vecs[v].b;
      last_idx = 0;
      do_read(vecs[v].rs, vecs[v].exp, 1'b0, 83, 1);
    end

    // Back-to-back: start held high, rs_sel wiggled mid-transaction.
    model_bytes[0] = 8'h5A;
    last_idx = 0;
    @(negedge clk);
    rs_sel = 1'b1;
    start  = 1'b1;
    dcnt   = 0;
    for (int i = 0; i < 4; i++) sb_q.push_back('{rdata: 8'h5A, to: 1'b0});
    for (int n = 1; n <= 340; n++) begin
      @(negedge clk);
      if (n == 260) start = 1'b0;
      rs_sel = (n >= 20 && n < 60) ? 1'b0 : 1'b1;
      if (busy && lcd_rs !== 1'b1) dcnt++;
      if (done) begin
        done_w.push_back(n);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("b2b_rdata", {24'h0, rdata}, {24'h0, e.rdata});
        end else chk("b2b_spurious_done", {31'h0, done}, 32'h0);
      end
    end
    chk("b2b_rs_stable", dcnt, 0);
    chk("b2b_done_count", done_w.size(), 4);
    for (int i = 0; i < done_w.size() && i < 4; i++)
      chk("b2b_done_cycle", done_w[i], 83 + 84 * i);
    sb_q.delete();

    // Abort: reset while E is high for the low nibble.
    model_bytes[0] = 8'h3C;
    @(negedge clk);
    rs_sel = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (73) @(negedge clk);
    chk("abort_in_eh_l", {31'h0, lcd_e}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_lcd_e", {31'h0, lcd_e}, 32'h0);
    chk("abort_lcd_rw", {31'h0, lcd_rw}, 32'h0);
    chk("abort_drv_en", {31'h0, drv_en}, 32'h1);
    chk("abort_rdata", {24'h0, rdata}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

`ifdef LCD_BUSY_POLL_EN
    model_bytes[0] = 8'h85;
    model_bytes[1] = 8'h85;
    model_bytes[2] = 8'h85;
    model_bytes[3] = 8'h05;
    last_idx = 3;
    do_read(1'b0, 8'h05, 1'b0, 83 + 3 * 132, 4);
    model_bytes[0] = 8'h85;
    last_idx = 0;
    do_read(1'b0, 8'h85, 1'b1, 83 + 7 * 132, 8);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
